// File: rtl/bus6502_pkg.sv
// Shared types for the 6502 bus target: FSM state encoding, bus-cycle record,
// and the address-window decode helper.
package bus6502_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_FETCH = 2'd1,
    RD_DRIVE = 2'd2,
    WR_WAIT  = 2'd3
  } bus_state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
  } bus_cycle_t;

  // A 16-bit-wide window shifts the mask to zero, so every address matches.
  function automatic logic addr_in_window(input logic [15:0] addr,
                                          input logic [15:0] base,
                                          input int          addr_bits);
    logic [15:0] mask;
    mask = 16'hFFFF << addr_bits;
    return ((addr ^ base) & mask) == 16'h0000;
  endfunction

endpackage

// File: rtl/phi2_sync.sv
// Brings the CPU phi2 clock into the eclk domain and turns its edges into
// single-eclk rise/fall pulses.
module phi2_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic eclk,
  input  logic ereset_n,
  input  logic clk2,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] SETTLE = 8'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   armed;
  logic [7:0]             settle;
  logic                   phi2;

  assign phi2 = sync[SYNC_STAGES-1];

  // After reset, wait for the chain to refill and then for phi2 to be seen
  // low, so a cycle already in flight at release never produces an edge.
  always_ff @(posedge eclk) begin
    if (!ereset_n) begin
      sync   <= '0;
      prev   <= 1'b0;
      armed  <= 1'b0;
      settle <= 8'd0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], clk2};
      prev <= phi2;
      if (settle != SETTLE) begin
        settle <= settle + 8'd1;
      end else if (!phi2) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = armed &  phi2 & ~prev;
  assign fall = armed & ~phi2 &  prev;

endmodule

// File: rtl/bus_target_6502.sv
// Memory-mapped 6502 bus target bridging phi2 bus cycles to a synchronous
// memory port. Optional bus trace outputs are enabled with BUS_TRACE_EN.
module bus_target_6502
  import bus6502_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          ADDR_BITS   = 12,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 eclk,
  input  logic                 ereset_n,
  input  logic [15:0]          ab,
  input  logic                 rw,
  input  logic                 clk2,
  input  logic [7:0]           db_i,
  output logic [7:0]           db_o,
  output logic                 db_oe,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_re,
  input  logic [7:0]           mem_rdata,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  output logic                 err
`ifdef BUS_TRACE_EN
  ,
  output logic                 trc_valid,
  output logic [15:0]          trc_addr,
  output logic [7:0]           trc_data,
  output logic                 trc_rw
`endif
);

  logic       rise;
  logic       fall;
  logic       rise_q;
  logic       fall_q;
  logic       in_window;
  bus_state_t state;

  phi2_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_phi2_sync (
    .eclk    (eclk),
    .ereset_n(ereset_n),
    .clk2    (clk2),
    .rise    (rise),
    .fall    (fall)
  );

  assign rise_q    = rise & ~fall;
  assign fall_q    = fall & ~rise;
  assign in_window = addr_in_window(ab, BASE_ADDR, ADDR_BITS);

  // In RD_FETCH, mem_re still high marks the request cycle; the following
  // cycle is when mem_rdata is valid and gets captured.
  always_ff @(posedge eclk) begin
    if (!ereset_n) begin
      state     <= IDLE;
      db_o      <= 8'h00;
      db_oe     <= 1'b0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      err       <= 1'b0;
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_q && in_window) begin
            mem_addr <= ab[ADDR_BITS-1:0];
            if (rw) begin
              state  <= RD_FETCH;
              mem_re <= 1'b1;
            end else begin
              state <= WR_WAIT;
            end
          end
        end
        RD_FETCH: begin
          if (fall_q) begin
            state <= IDLE;
            err   <= 1'b1;
          end else if (!mem_re) begin
            db_o  <= mem_rdata;
            db_oe <= 1'b1;
            state <= RD_DRIVE;
          end
        end
        RD_DRIVE: begin
          if (fall_q) begin
            db_oe <= 1'b0;
            state <= IDLE;
          end
        end
        WR_WAIT: begin
          if (fall_q) begin
            mem_wdata <= db_i;
            mem_we    <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUS_TRACE_EN
  logic [15:0] full_addr;
  bus_cycle_t  trc_rec;

  always_ff @(posedge eclk) begin
    if (!ereset_n) begin
      full_addr <= 16'h0000;
      trc_rec   <= '0;
      trc_valid <= 1'b0;
    end else begin
      trc_valid <= 1'b0;
      if (state == IDLE && rise_q && in_window) begin
        full_addr <= ab;
      end
      if (state == RD_DRIVE && fall_q) begin
        trc_rec   <= '{addr: full_addr, data: db_o, rw: 1'b1};
        trc_valid <= 1'b1;
      end
      if (state == WR_WAIT && fall_q) begin
        trc_rec   <= '{addr: full_addr, data: db_i, rw: 1'b0};
        trc_valid <= 1'b1;
      end
    end
  end

  assign trc_addr = trc_rec.addr;
  assign trc_data = trc_rec.data;
  assign trc_rw   = trc_rec.rw;
`endif

endmodule

// File: tb/tb_bus_target_6502.sv
// Table-driven bench for bus_target_6502 with a memory model and a scoreboard
// of expected memory-port transactions.
module tb_bus_target_6502;

  logic        eclk;
  logic        ereset_n;
  logic [15:0] ab;
  logic        rw;
  logic        clk2;
  logic [7:0]  db_i;
  logic [7:0]  db_o;
  logic        db_oe;
  logic [11:0] mem_addr;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        err;
`ifdef BUS_TRACE_EN
  logic        trc_valid;
  logic [15:0] trc_addr;
  logic [7:0]  trc_data;
  logic        trc_rw;
`endif

  bus_target_6502 #(
    .BASE_ADDR  (16'h0000),
    .ADDR_BITS  (12),
    .SYNC_STAGES(2)
  ) dut (
    .eclk     (eclk),
    .ereset_n (ereset_n),
    .ab       (ab),
    .rw       (rw),
    .clk2     (clk2),
    .db_i     (db_i),
    .db_o     (db_o),
    .db_oe    (db_oe),
    .mem_addr (mem_addr),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .err      (err)
`ifdef BUS_TRACE_EN
    ,
    .trc_valid(trc_valid),
    .trc_addr (trc_addr),
    .trc_data (trc_data),
    .trc_rw   (trc_rw)
`endif
  );

  initial eclk = 1'b0;
  always #5 eclk = ~eclk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory model: registered read, unwritten locations hold a fixed pattern.
  logic [7:0] wmem [int];

  function automatic logic [7:0] mem_default(input logic [11:0] a);
    return (a == 12'h123) ? 8'hA5 : (a[7:0] ^ 8'h5A);
  endfunction

  always @(posedge eclk) begin
    if (mem_we) wmem[int'(mem_addr)] = mem_wdata;
    if (mem_re) mem_rdata <= wmem.exists(int'(mem_addr)) ? wmem[int'(mem_addr)] : mem_default(mem_addr);
  end
  initial mem_rdata = 8'h00;

  typedef struct packed {
    logic        rw;
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   re_cnt, we_cnt, oe_cnt, oe_bad, excl_bad;
  logic [7:0] exp_data_cur;

  always @(negedge eclk) begin
    exp_t e;
    if (ereset_n) begin
      if (mem_re || mem_we) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=re%0d_we%0d_addr%0h required=none", mem_re, mem_we, mem_addr);
        end else begin
          e = sb.pop_front();
          check("sb_kind", 32'(mem_re), 32'(e.rw));
          check("sb_addr", 32'(mem_addr), 32'(e.addr));
          if (mem_we) check("sb_wdata", 32'(mem_wdata), 32'(e.data));
        end
      end
      if (mem_re) re_cnt++;
      if (mem_we) we_cnt++;
      if (db_oe) begin
        oe_cnt++;
        if (db_o !== exp_data_cur) oe_bad++;
      end
      if (int'(mem_re) + int'(mem_we) + int'(db_oe) > 1) excl_bad++;
    end
  end

`ifdef BUS_TRACE_EN
  bus6502_pkg::bus_cycle_t trq[$];
  always @(negedge eclk) begin
    bus6502_pkg::bus_cycle_t t;
    if (ereset_n && trc_valid) begin
      if (trq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL trc_unexpected actual=%0h required=none", trc_addr);
      end else begin
        t = trq.pop_front();
        check("trc_addr", 32'(trc_addr), 32'(t.addr));
        check("trc_data", 32'(trc_data), 32'(t.data));
        check("trc_rw", 32'(trc_rw), 32'(t.rw));
      end
    end
  end
`endif

  // Queue the memory-port transaction (and trace record) a cycle should produce.
  task automatic push_exp(input logic [15:0] a, input logic r, input logic [7:0] d, input logic complete);
    exp_t e;
    e.rw = r;
    e.addr = a[11:0];
    e.data = r ? 8'h00 : d;
    sb.push_back(e);
`ifdef BUS_TRACE_EN
    if (complete) trq.push_back('{addr: a, data: d, rw: r});
`else
    if (complete) exp_data_cur = exp_data_cur;
`endif
  endtask

  task automatic clear_counts();
    re_cnt = 0; we_cnt = 0; oe_cnt = 0; oe_bad = 0; excl_bad = 0;
  endtask

  task automatic phi2_cycle(input logic [15:0] a, input logic r, input logic [7:0] d,
                            input int high, input int low);
    ab = a; rw = r; db_i = d;
    clear_counts();
    @(posedge eclk); #2 clk2 = 1'b1;
    repeat (high) @(posedge eclk);
    #2 clk2 = 1'b0;
    repeat (low) @(posedge eclk);
    #1;
  endtask

  typedef struct {
    logic [15:0] ab;
    logic        rw;
    logic [7:0]  dbi;
    int          high;
    int          exp_re;
    int          exp_we;
    int          exp_oe;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    ereset_n = 1'b0; clk2 = 1'b0; ab = 16'h0000; rw = 1'b1; db_i = 8'h00;
    exp_data_cur = 8'h00;
    clear_counts();
    repeat (3) @(posedge eclk);
    #1;
    check("rst_strobes", {29'b0, db_oe, mem_re, mem_we}, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_data", {8'h0, db_o, mem_wdata, 8'h0}, 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    ereset_n = 1'b1;
    repeat (6) @(posedge eclk);

    //          ab        rw    dbi    H  re we oe data
    vecs[0] = '{16'h0123, 1'b1, 8'h00, 8, 1, 0, 6, 8'hA5};
    vecs[1] = '{16'h0FFF, 1'b0, 8'h3C, 8, 0, 1, 0, 8'h00};
    vecs[2] = '{16'h1000, 1'b1, 8'h00, 8, 0, 0, 0, 8'h00};
    vecs[3] = '{16'h1000, 1'b0, 8'h99, 8, 0, 0, 0, 8'h00};
    vecs[4] = '{16'h0000, 1'b1, 8'h00, 8, 1, 0, 6, 8'h5A};
    vecs[5] = '{16'h0800, 1'b0, 8'hC3, 8, 0, 1, 0, 8'h00};
    vecs[6] = '{16'hF123, 1'b1, 8'h00, 8, 0, 0, 0, 8'h00};
    vecs[7] = '{16'h0FFF, 1'b1, 8'h00, 8, 1, 0, 6, 8'h3C};
    vecs[8] = '{16'h0123, 1'b1, 8'h00, 4, 1, 0, 2, 8'hA5};

    for (int i = 0; i < 9; i++) begin
      exp_data_cur = vecs[i].exp_data;
      if (vecs[i].exp_re == 1) push_exp(vecs[i].ab, 1'b1, vecs[i].exp_data, 1'b1);
      if (vecs[i].exp_we == 1) push_exp(vecs[i].ab, 1'b0, vecs[i].dbi, 1'b1);
      phi2_cycle(vecs[i].ab, vecs[i].rw, vecs[i].dbi, vecs[i].high, 6);
      $display("vec %0d ab=%h rw=%0d dbi=%h re=%0d we=%0d oe=%0d", i, vecs[i].ab, vecs[i].rw,
               vecs[i].dbi, re_cnt, we_cnt, oe_cnt);
      check($sformatf("v%0d_re", i), 32'(re_cnt), 32'(vecs[i].exp_re));
      check($sformatf("v%0d_we", i), 32'(we_cnt), 32'(vecs[i].exp_we));
      check($sformatf("v%0d_oe", i), 32'(oe_cnt), 32'(vecs[i].exp_oe));
      check($sformatf("v%0d_dbo", i), 32'(oe_bad), 32'h0);
      check($sformatf("v%0d_excl", i), 32'(excl_bad), 32'h0);
      check($sformatf("v%0d_oe_end", i), 32'(db_oe), 32'h0);
    end
    check("err_clean", 32'(err), 32'h0);

    // Fast phi2 on a read: the fetch is cut short and err latches.
    exp_data_cur = 8'hA5;
    push_exp(16'h0123, 1'b1, 8'hA5, 1'b0);
    phi2_cycle(16'h0123, 1'b1, 8'h00, 1, 6);
    $display("fast read re=%0d oe=%0d err=%0d", re_cnt, oe_cnt, err);
    check("fast_re", 32'(re_cnt), 32'h1);
    check("fast_oe", 32'(oe_cnt), 32'h0);
    check("fast_err", 32'(err), 32'h1);

    push_exp(16'h0800, 1'b0, 8'h11, 1'b1);
    phi2_cycle(16'h0800, 1'b0, 8'h11, 8, 6);
    $display("write after abort we=%0d err=%0d", we_cnt, err);
    check("sticky_we", 32'(we_cnt), 32'h1);
    check("sticky_err", 32'(err), 32'h1);

    // Reset between phi2 rise and fall of a write.
    ab = 16'h0FFF; rw = 1'b0; db_i = 8'h77;
    clear_counts();
    @(posedge eclk); #2 clk2 = 1'b1;
    repeat (5) @(posedge eclk);
    #1 ereset_n = 1'b0;
    repeat (2) @(posedge eclk);
    #2 clk2 = 1'b0;
    repeat (2) @(posedge eclk);
    #1;
    check("midrst_err", 32'(err), 32'h0);
    check("midrst_wdata", 32'(mem_wdata), 32'h0);
    ereset_n = 1'b1;
    repeat (8) @(posedge eclk);
    #1;
    $display("reset mid-write we=%0d", we_cnt);
    check("midrst_we", 32'(we_cnt), 32'h0);

    push_exp(16'h0FFF, 1'b0, 8'h3C, 1'b1);
    phi2_cycle(16'h0FFF, 1'b0, 8'h3C, 8, 6);
    $display("write after reset we=%0d", we_cnt);
    check("postrst_we", 32'(we_cnt), 32'h1);
    exp_data_cur = 8'h3C;
    push_exp(16'h0FFF, 1'b1, 8'h3C, 1'b1);
    phi2_cycle(16'h0FFF, 1'b1, 8'h00, 8, 6);
    $display("readback after reset re=%0d oe=%0d", re_cnt, oe_cnt);
    check("postrst_oe", 32'(oe_cnt), 32'h6);
    check("postrst_dbo", 32'(oe_bad), 32'h0);

    // Reset released while phi2 is already high: that cycle must be ignored.
    ereset_n = 1'b0; clk2 = 1'b1; ab = 16'h0123; rw = 1'b1;
    repeat (2) @(posedge eclk);
    #1 ereset_n = 1'b1;
    clear_counts();
    repeat (6) @(posedge eclk);
    #2 clk2 = 1'b0;
    repeat (6) @(posedge eclk);
    #1;
    $display("release mid-cycle re=%0d oe=%0d", re_cnt, oe_cnt);
    check("relhigh_re", 32'(re_cnt), 32'h0);
    check("relhigh_oe", 32'(oe_cnt), 32'h0);
    exp_data_cur = 8'hA5;
    push_exp(16'h0123, 1'b1, 8'hA5, 1'b1);
    phi2_cycle(16'h0123, 1'b1, 8'h00, 8, 6);
    $display("read after release re=%0d oe=%0d", re_cnt, oe_cnt);
    check("relhigh_next_re", 32'(re_cnt), 32'h1);
    check("relhigh_next_oe", 32'(oe_cnt), 32'h6);

    check("sb_drained", 32'(sb.size()), 32'h0);
`ifdef BUS_TRACE_EN
    check("trc_drained", 32'(trq.size()), 32'h0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_target_6502.md
BUS_TARGET_6502 -- requirements
Module: bus_target_6502

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0000, meaning window base; low ADDR_BITS bits are zero.
REQ-002 SHALL have parameter ADDR_BITS, default 12, meaning window size 2^ADDR_BITS bytes, range 1..16.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning phi2 synchronizer depth, minimum 2.
REQ-004 SHALL have port eclk, input, 1, emulation clock; sole clock of the block.
REQ-005 SHALL have port ereset_n, input, 1, reset, synchronous to eclk, active-low.
REQ-006 SHALL have ports ab, input, 16, CPU address bus; and rw, input, 1, CPU read(1)/write(0).
REQ-007 SHALL have port clk2, input, 1, CPU phi2, asynchronous to eclk.
REQ-008 SHALL have ports db_i, input, 8, CPU-driven write data; db_o, output, 8, read data; db_oe, output, 1, drive enable for db_o.
REQ-009 SHALL have memory-port signals mem_addr, output, ADDR_BITS; mem_re, output, 1; mem_rdata, input, 8, valid one eclk after mem_re; mem_we, output, 1; mem_wdata, output, 8.
REQ-010 SHALL have port err, output, 1, sticky flag for a read that could not complete.

Function
REQ-011 SHALL pass clk2 through SYNC_STAGES flops, then detect rise and fall as one-eclk pulses.
REQ-012 SHALL treat ab as in window when ab[15:ADDR_BITS] equals BASE_ADDR[15:ADDR_BITS]; ADDR_BITS=16 is always in window.
REQ-013 SHALL implement states IDLE, RD_FETCH, RD_DRIVE, WR_WAIT.
REQ-014 SHALL latch ab[ADDR_BITS-1:0] into mem_addr and sample rw in IDLE on phi2 rise.
REQ-015 SHALL leave IDLE only for an in-window phi2 rise, going to RD_FETCH if rw=1 and WR_WAIT if rw=0; out-of-window cycles stay IDLE with no outputs asserted.
REQ-016 SHALL pulse mem_re for the one eclk on which RD_FETCH is entered, then capture mem_rdata into db_o and go to RD_DRIVE on the next eclk.
REQ-017 SHALL assert db_oe in RD_DRIVE only, hold db_o stable, and return to IDLE on the eclk after phi2 fall.
REQ-018 SHALL, if phi2 fall arrives while in RD_FETCH, abort to IDLE without asserting db_oe and set err.
REQ-019 SHALL, in WR_WAIT on phi2 fall, load mem_wdata from db_i, pulse mem_we for one eclk, and return to IDLE.
REQ-020 SHALL drop simultaneous rise and fall pulses; they cannot occur with SYNC_STAGES at least 2.
REQ-021 SHALL keep mem_re, mem_we and db_oe mutually exclusive, at most one per phi2 cycle each.

Reset
REQ-022 SHALL, while ereset_n=0 on an eclk edge, force IDLE and clear db_oe, mem_re, mem_we, db_o, mem_addr, mem_wdata, err and all synchronizer flops to 0.
REQ-023 SHALL, on reset during an open write, suppress the mem_we pulse; reset during RD_DRIVE drops db_oe on the next eclk.
REQ-024 SHALL ignore any phi2 cycle already in progress at reset release until a fresh rise is detected.

Configuration
REQ-025 SHALL, with BUS_TRACE_EN defined, add outputs trc_valid (1), trc_addr (16), trc_data (8) and trc_rw (1), pulsing trc_valid one eclk per completed in-window cycle with the full address and transferred data.
REQ-026 SHALL, without BUS_TRACE_EN, omit the trace ports and logic, with identical bus behaviour.

Structure
REQ-027 SHALL place the state enum and the bus-cycle record type (addr, data, rw) in shared package bus6502_pkg.
REQ-028 SHALL implement the synchronizer and edge detect as sub-module phi2_sync with ports eclk, ereset_n, clk2, rise, fall.

Verification
REQ-029 SHALL cover read: BASE_ADDR=16'h0000, ab=16'h0123, rw=1, mem_rdata=8'hA5 -> single mem_re with mem_addr=12'h123; db_oe=1, db_o=8'hA5 until the eclk after phi2 fall.
REQ-030 SHALL cover write: ab=16'h0FFF, rw=0, db_i=8'h3C -> single mem_we after phi2 fall with mem_addr=12'hFFF, mem_wdata=8'h3C; db_oe stays 0.
REQ-031 SHALL cover out of window: ab=16'h1000, both rw values -> no mem_re, mem_we or db_oe; state stays IDLE.
REQ-032 SHALL cover fast phi2 (high pulse 1 eclk after synchronization) on read -> err=1, db_oe never 1, err held until reset.
REQ-033 SHALL cover reset mid-write: ereset_n=0 between phi2 rise and fall -> no mem_we; next normal cycle completes correctly.
REQ-034 SHALL cover, with BUS_TRACE_EN, a read then a write -> two trc_valid pulses carrying {16'h0123, 8'hA5, 1} and {16'h0FFF, 8'h3C, 0}.
